// File: rtl/rv32_mmio_uart_tx_pkg.sv
// rv32_mmio_uart_tx_pkg
//   Shared types for the MMIO UART transmitter: the core data-request bus
//   record, the register offsets inside the 16-byte window, and the
//   transmitter state encoding.
package rv32_mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_request_t;

  localparam logic [3:0] UART_REG_DATA   = 4'h0;
  localparam logic [3:0] UART_REG_STATUS = 4'h4;
  localparam logic [3:0] UART_REG_DIV    = 4'h8;
  localparam logic [3:0] UART_REG_CTRL   = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Byte lane bits of the window offset are ignored: registers are word-wide.
  function automatic logic [3:0] uart_reg_offset(input logic [31:0] off);
    return {off[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_mmio_uart_tx_fifo.sv
// rv32_sync_fifo
//   Single-clock FIFO with registered pointers, intended to be reused by a
//   future receive path. Pop is serviced before push, so a push into a full
//   FIFO is accepted when a pop happens in the same cycle.
// Ports
//   clk, resetn        clock, async active-low reset (discards contents)
//   push_i, wdata_i    write strobe and data (ignored when full and no pop)
//   pop_i              read strobe (ignored when empty)
//   rdata_o            head entry, valid while !empty_o
//   full_o, empty_o    occupancy flags
module rv32_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rv32_mmio_uart_tx.sv
// rv32_mmio_uart_tx
//   MMIO responder for one slot of the core data-request bus. Writes to DATA
//   queue bytes in a TX FIFO which are sent 8N1 on uart_tx. A request accepted
//   in cycle N is answered with a one-cycle request_done in N+1; read data is
//   registered at the same edge and held until the next accepted read.
//   Optional feature macro: RV32_UART_TX_IRQ_EN (adds irq port and CTRL.irq_en).
// Ports
//   clk, resetn     clock, async active-low reset
//   data_request    core data request (op, addr, data)
//   request_done    one-cycle response pulse
//   data_out        read data, held between reads
//   uart_tx         serial line, idle high
//   irq             (RV32_UART_TX_IRQ_EN only) irq_en & fifo empty & idle
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for DIV+1 cycles
// DATA  | 8 data bits LSB first, DIV+1 cycles each
// STOP  | stop bit (high) for DIV+1 cycles
module rv32_mmio_uart_tx
  import rv32_mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic            clk,
  input  logic            resetn,
  input  memory_request_t data_request,
  output logic            request_done,
  output logic [31:0]     data_out,
  output logic            uart_tx
`ifdef RV32_UART_TX_IRQ_EN
  ,
  output logic            irq
`endif
);

  logic [31:0]    offset;
  logic [3:0]     reg_off;
  logic           in_win, accept, acc_rd, acc_wr;
  logic           req_done_q;
  logic [31:0]    data_out_q, rd_val, ctrl_rd;
  logic [15:0]    div_q;
  logic           ovf_q;
  logic           irq_pend, busy;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;

  uart_tx_state_t state_q;
  logic [15:0]    cnt_q, frame_div_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q;

  // Unsigned offset from base: anything outside [0,15] is someone else's slot.
  assign offset  = data_request.addr - BASE_ADDR;
  assign reg_off = uart_reg_offset(offset);
  assign in_win  = (offset[31:4] == 28'd0);
  assign accept  = (data_request.op != MEM_NONE) && in_win && !req_done_q;
  assign acc_rd  = accept && (data_request.op == MEM_READ);
  assign acc_wr  = accept && (data_request.op == MEM_WRITE);

  logic unused_bits;
  assign unused_bits = ^{data_request.data[31:16], offset[1:0]};

  assign busy      = (state_q != IDLE);
  assign fifo_push = acc_wr && (reg_off == UART_REG_DATA);
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && (cnt_q == 16'd0)));

  rv32_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .wdata_i (data_request.data[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef RV32_UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, wr_ctrl;

  assign wr_ctrl = acc_wr && (reg_off == UART_REG_CTRL);

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl) irq_en_d = data_request.data[0];
  end

  // Uses the next enable so clearing CTRL drops irq alongside request_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_d & fifo_empty & !busy;
    end
  end

  assign irq      = irq_q;
  assign irq_pend = irq_q;
  assign ctrl_rd  = {31'd0, irq_en_q};
`else
  assign irq_pend = 1'b0;
  assign ctrl_rd  = 32'd0;
`endif

  always_comb begin
    rd_val = 32'd0;
    case (reg_off)
      UART_REG_STATUS: rd_val = {27'd0, ovf_q, busy, fifo_full, fifo_empty, irq_pend};
      UART_REG_DIV:    rd_val = {16'd0, div_q};
      UART_REG_CTRL:   rd_val = ctrl_rd;
      default:         rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_done_q <= 1'b0;
      data_out_q <= 32'd0;
      div_q      <= DEFAULT_DIV;
      ovf_q      <= 1'b0;
    end else begin
      req_done_q <= accept;
      if (acc_rd) data_out_q <= rd_val;
      if (acc_wr && (reg_off == UART_REG_DIV)) div_q <= data_request.data[15:0];
      // A push into a full FIFO only loses the byte when no pop frees a slot.
      if (fifo_push && fifo_full && !fifo_pop)
        ovf_q <= 1'b1;
      else if (acc_wr && (reg_off == UART_REG_STATUS) && data_request.data[4])
        ovf_q <= 1'b0;
    end
  end

  // The divisor is latched per frame so a DIV write never stretches a frame
  // that is already on the line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      frame_div_q <= 16'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      tx_q        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= START;
            tx_q        <= 1'b0;
            cnt_q       <= div_q;
            frame_div_q <= div_q;
            shift_q     <= fifo_rdata;
          end
        end
        START: begin
          if (cnt_q == 16'd0) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= 3'd0;
            cnt_q   <= frame_div_q;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= frame_div_q;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == 16'd0) begin
            if (!fifo_empty) begin
              state_q     <= START;
              tx_q        <= 1'b0;
              cnt_q       <= div_q;
              frame_div_q <= div_q;
              shift_q     <= fifo_rdata;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign request_done = req_done_q;
  assign data_out     = data_out_q;
  assign uart_tx      = tx_q;

endmodule

// File: tb/tb_rv32_mmio_uart_tx.sv
// tb_rv32_mmio_uart_tx
//   Directed bench for rv32_mmio_uart_tx with default parameters. Builds with
//   or without RV32_UART_TX_IRQ_EN; the irq section is only present when the
//   macro is defined.
module tb_rv32_mmio_uart_tx;
  import rv32_mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic            clk;
  logic            resetn;
  memory_request_t data_request;
  logic            request_done;
  logic [31:0]     data_out;
  logic            uart_tx;
`ifdef RV32_UART_TX_IRQ_EN
  logic            irq;
  localparam logic [31:0] CTRL_RB = 32'd1;
`else
  localparam logic [31:0] CTRL_RB = 32'd0;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd  = 32'd0;

  rv32_mmio_uart_tx dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_request (data_request),
    .request_done (request_done),
    .data_out     (data_out),
    .uart_tx      (uart_tx)
`ifdef RV32_UART_TX_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read: done only in N+1, data valid in N+1 and still held in N+2.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    data_request.op   = MEM_READ;
    data_request.addr = addr;
    data_request.data = 32'd0;
    step();
    chk({tag, " done"}, {31'd0, request_done}, 32'd1);
    chk({tag, " data"}, data_out, exp);
    data_request.op = MEM_NONE;
    step();
    chk({tag, " done_low"}, {31'd0, request_done}, 32'd0);
    chk({tag, " hold"}, data_out, exp);
    last_rd = exp;
  endtask

  // Write: done pulse, data_out keeps the last read value.
  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    data_request.op   = MEM_WRITE;
    data_request.addr = addr;
    data_request.data = wdata;
    step();
    chk({tag, " done"}, {31'd0, request_done}, 32'd1);
    chk({tag, " data_keep"}, data_out, last_rd);
    data_request.op = MEM_NONE;
    step();
  endtask

  initial begin
    logic [7:0] byte_v;
    logic       e;
    int         idx;
    int         hits;
    int         waited;

    resetn = 1'b0;
    data_request = '0;
    data_request.op = MEM_NONE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx", {31'd0, uart_tx}, 32'd1);
    chk("rst done", {31'd0, request_done}, 32'd0);
    resetn = 1'b1;
    step();
    chk("rst data_out", data_out, 32'd0);

    rd(BASE + 32'h4, 32'h2, "status_reset");
    rd(BASE + 32'h8, 32'd867, "div_reset");

    // 0xA5 at DIV=3: 4 cycles per bit, bits 1,0,1,0,0,1,0,1.
    wr(BASE + 32'h8, 32'd3, "div3");
    wr(BASE + 32'h0, 32'hA5, "data_a5");
    byte_v = 8'hA5;
    for (int c = 0; c < 42; c++) begin
      idx = c / 4;
      if (idx == 0)      e = 1'b0;
      else if (idx >= 9) e = 1'b1;
      else               e = byte_v[idx-1];
      chk($sformatf("line_a5 c%0d", c), {31'd0, uart_tx}, {31'd0, e});
      step();
    end
    rd(BASE + 32'h4, 32'h2, "status_after_frame");

    rd(BASE + 32'h0, 32'h0, "data_read_zero");
    rd(BASE + 32'hA, 32'd3, "div_bytelane");
    wr(BASE + 32'hC, 32'd1, "ctrl_set");
    rd(BASE + 32'hF, CTRL_RB, "ctrl_rb");
    wr(BASE + 32'hC, 32'd0, "ctrl_clr");

    // Outside the window: never answered.
    data_request.op   = MEM_READ;
    data_request.addr = BASE + 32'h10;
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (request_done) hits++;
    end
    chk("oow_read no_done", hits, 0);
    data_request.op   = MEM_WRITE;
    data_request.addr = BASE - 32'h4;
    data_request.data = 32'h55;
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (request_done) hits++;
    end
    chk("oow_write no_done", hits, 0);
    data_request.op = MEM_NONE;
    step();
    rd(BASE + 32'h4, 32'h2, "status_after_oow");

    // Overflow: first byte popped at once, 8 queued, 10th push overflows.
    wr(BASE + 32'h8, 32'd100, "div100");
    rd(BASE + 32'h8, 32'd100, "div100_rb");
    for (int i = 0; i < 9; i++) begin
      wr(BASE + 32'h0, 32'h10 + i, $sformatf("push%0d", i + 1));
    end
    rd(BASE + 32'h4, 32'h0C, "status_full");
    wr(BASE + 32'h0, 32'hEE, "push10");
    rd(BASE + 32'h4, 32'h1C, "status_ovf");
    wr(BASE + 32'h4, 32'h10, "ovf_clear");
    rd(BASE + 32'h4, 32'h0C, "status_ovf_cleared");

    // Reset while the line is low mid-frame.
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 3000) begin
      step();
      waited++;
    end
    chk("mid_frame low found", {31'd0, uart_tx}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("reset tx immediate", {31'd0, uart_tx}, 32'd1);
    chk("reset done", {31'd0, request_done}, 32'd0);
    chk("reset data_out", data_out, 32'd0);
    step();
    resetn = 1'b1;
    last_rd = 32'd0;
    step();
    rd(BASE + 32'h4, 32'h2, "status_post_reset");
    rd(BASE + 32'h8, 32'd867, "div_post_reset");

`ifdef RV32_UART_TX_IRQ_EN
    wr(BASE + 32'h8, 32'd3, "irq div3");
    wr(BASE + 32'hC, 32'd1, "irq ctrl1");
    chk("irq idle_empty", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h4, 32'h3, "irq status_pend");
    wr(BASE + 32'h0, 32'h3C, "irq data");
    chk("irq busy0", {31'd0, irq}, 32'd0);
    for (int c = 0; c < 40; c++) step();
    chk("irq stop_last", {31'd0, irq}, 32'd0);
    chk("irq line_high", {31'd0, uart_tx}, 32'd1);
    step();
    chk("irq rise", {31'd0, irq}, 32'd1);
    wr(BASE + 32'hC, 32'd0, "irq ctrl0");
    chk("irq fall", {31'd0, irq}, 32'd0);
    rd(BASE + 32'h4, 32'h2, "irq status_cleared");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
